mem_port_arbiter: RTL and testbench

- Arbitrates the instruction-cache refill port and the data-cache refill and write port onto one shared sram-like memory port (req/addr_ok/data_ok).
- Sits between the I/D caches and the AXI bridge.
- Each transaction is sequenced through an address phase and a counted data phase.
- Fixed priority (data write > data read > inst read) with an anti-starvation override for instruction fetch.

---
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between I-cache refill and D-cache refill/write traffic.
// Latency: grant pulses in the request cycle, mem_req_o rises the next cycle, read beats forwarded combinationally.
// Backpressure: requests are held until their grant pulse; memory stalls through addr_ok/data_ok.
module mem_port_arbiter #(
  parameter int LINE_WORDS   = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        inst_req_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_uncached_i,
  output logic        inst_grant_o,
  output logic        inst_rvalid_o,
  output logic        inst_rlast_o,
  output logic [31:0] inst_rdata_o,
  input  logic        data_rreq_i,
  input  logic [31:0] data_raddr_i,
  input  logic        data_uncached_i,
  output logic        data_rgrant_o,
  output logic        data_rvalid_o,
  output logic        data_rlast_o,
  output logic [31:0] data_rdata_o,
  input  logic        data_wreq_i,
  input  logic [31:0] data_waddr_i,
  input  logic [3:0]  data_wstrb_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_wgrant_o,
  output logic        data_wdone_o,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_len_o,
  input  logic        mem_addr_ok_i,
  input  logic        mem_data_ok_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  typedef enum logic [1:0] {OWN_INST, OWN_DRD, OWN_DWR} owner_t;

  localparam logic [3:0]    LINE_LEN   = 4'(LINE_WORDS - 1);
  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  state_t        state, state_nxt;
  owner_t        owner, sel_owner;
  logic          take;
  logic          inst_win;
  logic [31:0]   sel_addr;
  logic [3:0]    sel_len;
  logic          sel_wr;
  logic [31:0]   lat_addr, lat_wdata;
  logic [3:0]    lat_strb, lat_len;
  logic          lat_wr;
  logic [3:0]    beat;
  logic [SW-1:0] starve;
  logic          beat_ok, beat_last;

  // Inst wins when forced by starvation or when no data request competes
  assign inst_win = inst_req_i && ((starve == STARVE_MAX) || (!data_wreq_i && !data_rreq_i));

  // Winner selection in IDLE and next-state sequencing of address/data phases
  always_comb begin
    state_nxt     = state;
    take          = 1'b0;
    sel_owner     = OWN_INST;
    sel_addr      = inst_addr_i;
    sel_wr        = 1'b0;
    sel_len       = LINE_LEN;
    inst_grant_o  = 1'b0;
    data_rgrant_o = 1'b0;
    data_wgrant_o = 1'b0;
    case (state)
      IDLE: begin
        // Grants are combinational, so hold them off while reset is asserted
        if (!reset_i) begin
          if (inst_win) begin
            take         = 1'b1;
            inst_grant_o = 1'b1;
            sel_owner    = OWN_INST;
            sel_addr     = inst_addr_i;
            sel_len      = inst_uncached_i ? 4'd0 : LINE_LEN;
          end else if (data_wreq_i) begin
            take          = 1'b1;
            data_wgrant_o = 1'b1;
            sel_owner     = OWN_DWR;
            sel_addr      = data_waddr_i;
            sel_wr        = 1'b1;
            sel_len       = 4'd0;
          end else if (data_rreq_i) begin
            take          = 1'b1;
            data_rgrant_o = 1'b1;
            sel_owner     = OWN_DRD;
            sel_addr      = data_raddr_i;
            sel_len       = data_uncached_i ? 4'd0 : LINE_LEN;
          end
        end
        if (take) state_nxt = ADDR;
      end
      ADDR:    if (mem_addr_ok_i) state_nxt = DATA;
      DATA:    if (mem_data_ok_i && beat == lat_len) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Capture the winning transaction so mem_* stays stable while memory stalls
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      owner     <= OWN_INST;
      lat_addr  <= '0;
      lat_wr    <= 1'b0;
      lat_strb  <= '0;
      lat_wdata <= '0;
      lat_len   <= '0;
    end else if (take) begin
      owner     <= sel_owner;
      lat_addr  <= sel_addr;
      lat_wr    <= sel_wr;
      lat_strb  <= sel_wr ? data_wstrb_i : 4'd0;
      lat_wdata <= sel_wr ? data_wdata_i : 32'd0;
      lat_len   <= sel_len;
    end
  end

  // Beat counter: restarts when the address phase is accepted
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                             beat <= '0;
    else if (state == ADDR && mem_addr_ok_i) beat <= '0;
    else if (beat_ok)                        beat <= beat + 4'd1;
  end

  // Starve counter: counts data grants that overtook a pending inst request
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                                                         starve <= '0;
    else if (inst_grant_o || !inst_req_i)                                starve <= '0;
    else if ((data_wgrant_o || data_rgrant_o) && starve != STARVE_MAX) starve <= starve + 1'b1;
  end

  assign beat_ok   = (state == DATA) && mem_data_ok_i;
  assign beat_last = (beat == lat_len);

  assign inst_rvalid_o = beat_ok && (owner == OWN_INST);
  assign data_rvalid_o = beat_ok && (owner == OWN_DRD);
  assign data_wdone_o  = beat_ok && (owner == OWN_DWR);
  assign inst_rlast_o  = inst_rvalid_o && beat_last;
  assign data_rlast_o  = data_rvalid_o && beat_last;
  assign inst_rdata_o  = inst_rvalid_o ? mem_rdata_i : 32'd0;
  assign data_rdata_o  = data_rvalid_o ? mem_rdata_i : 32'd0;

  assign mem_req_o   = (state == ADDR);
  assign mem_wr_o    = lat_wr;
  assign mem_addr_o  = lat_addr;
  assign mem_wstrb_o = lat_strb;
  assign mem_wdata_o = lat_wdata;
  assign mem_len_o   = lat_len;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic.
// Requesters and memory are modelled by tasks; expectations come from a transaction-level model.
// Inputs change 1 time unit after the rising edge, outputs are sampled 1 unit later.
module tb_mem_port_arbiter;
  localparam int LW = 8;
  localparam int SL = 4;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        inst_req_i, inst_uncached_i;
  logic [31:0] inst_addr_i;
  logic        inst_grant_o, inst_rvalid_o, inst_rlast_o;
  logic [31:0] inst_rdata_o;
  logic        data_rreq_i, data_uncached_i;
  logic [31:0] data_raddr_i;
  logic        data_rgrant_o, data_rvalid_o, data_rlast_o;
  logic [31:0] data_rdata_o;
  logic        data_wreq_i;
  logic [31:0] data_waddr_i, data_wdata_i;
  logic [3:0]  data_wstrb_i;
  logic        data_wgrant_o, data_wdone_o;
  logic        mem_req_o, mem_wr_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o, mem_len_o;
  logic        mem_addr_ok_i, mem_data_ok_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;
  int m_starve = 0;

  // Observations captured by the memory-side task
  logic [31:0] o_addr, o_wdata;
  logic [3:0]  o_len, o_strb;
  logic        o_wr, o_stable, o_fell;
  int          o_gap;
  logic        o_iv[16], o_dv[16], o_wd[16], o_il[16], o_dl[16];
  logic [31:0] o_ird[16], o_drd[16];
  logic [31:0] beat_dat[16];

  mem_port_arbiter #(.LINE_WORDS(LW), .STARVE_LIMIT(SL)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_uncached_i(inst_uncached_i),
    .inst_grant_o(inst_grant_o), .inst_rvalid_o(inst_rvalid_o), .inst_rlast_o(inst_rlast_o),
    .inst_rdata_o(inst_rdata_o),
    .data_rreq_i(data_rreq_i), .data_raddr_i(data_raddr_i), .data_uncached_i(data_uncached_i),
    .data_rgrant_o(data_rgrant_o), .data_rvalid_o(data_rvalid_o), .data_rlast_o(data_rlast_o),
    .data_rdata_o(data_rdata_o),
    .data_wreq_i(data_wreq_i), .data_waddr_i(data_waddr_i), .data_wstrb_i(data_wstrb_i),
    .data_wdata_i(data_wdata_i), .data_wgrant_o(data_wgrant_o), .data_wdone_o(data_wdone_o),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_wdata_o(mem_wdata_o), .mem_len_o(mem_len_o),
    .mem_addr_ok_i(mem_addr_ok_i), .mem_data_ok_i(mem_data_ok_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clock_i = ~clock_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Model: requester codes 1=inst, 2=data read, 4=data write
  function automatic int pick(bit w, bit r, bit i);
    if (i && m_starve == SL) return 1;
    if (w) return 4;
    if (r) return 2;
    if (i) return 1;
    return 0;
  endfunction

  function automatic void model_grant(int w, bit inst_pending);
    if (w == 1) m_starve = 0;
    else if (inst_pending) m_starve = (m_starve < SL) ? m_starve + 1 : SL;
  endfunction

  function automatic int exp_len(int w, bit unc);
    return (w == 4 || unc) ? 0 : LW - 1;
  endfunction

  task automatic cyc();
    if (!inst_req_i) m_starve = 0;
    @(posedge clock_i);
    #1;
  endtask

  task automatic wait_grant(output int who, output int waited, input int budget);
    who = 0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (inst_grant_o || data_rgrant_o || data_wgrant_o) begin
        who = (inst_grant_o ? 1 : 0) + (data_rgrant_o ? 2 : 0) + (data_wgrant_o ? 4 : 0);
        waited = i;
        return;
      end
      cyc();
    end
  endtask

  task automatic serve(input int who, input bit drop, input int adelay, input int nbeats, input bit scramble);
    int gaps;
    cyc();
    if (drop) begin
      if (who == 1) inst_req_i = 1'b0;
      if (who == 2) data_rreq_i = 1'b0;
      if (who == 4) data_wreq_i = 1'b0;
    end
    if (scramble) begin
      inst_addr_i = $urandom; data_raddr_i = $urandom; data_waddr_i = $urandom;
      data_wdata_i = $urandom; data_wstrb_i = 4'($urandom);
      inst_uncached_i = ~inst_uncached_i; data_uncached_i = ~data_uncached_i;
    end
    o_stable = 1'b1;
    o_gap = 0;
    for (int k = 0; k <= adelay; k++) begin
      mem_addr_ok_i = (k == adelay);
      #1;
      if (k == 0) begin
        o_addr = mem_addr_o; o_len = mem_len_o; o_wr = mem_wr_o;
        o_strb = mem_wstrb_o; o_wdata = mem_wdata_o;
      end
      if (mem_req_o !== 1'b1 || mem_addr_o !== o_addr || mem_len_o !== o_len || mem_wr_o !== o_wr ||
          mem_wstrb_o !== o_strb || mem_wdata_o !== o_wdata) o_stable = 1'b0;
      cyc();
    end
    mem_addr_ok_i = 1'b0;
    #1;
    o_fell = (mem_req_o === 1'b0);
    for (int b = 0; b < nbeats; b++) begin
      gaps = $urandom_range(0, 1);
      repeat (gaps) begin
        mem_data_ok_i = 1'b0;
        mem_rdata_i = $urandom;
        #1;
        if (inst_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || data_wdone_o !== 1'b0 || mem_req_o !== 1'b0) o_gap++;
        cyc();
      end
      mem_data_ok_i = 1'b1;
      mem_rdata_i = beat_dat[b];
      #1;
      o_iv[b] = inst_rvalid_o; o_dv[b] = data_rvalid_o; o_wd[b] = data_wdone_o;
      o_il[b] = inst_rlast_o; o_dl[b] = data_rlast_o;
      o_ird[b] = inst_rdata_o; o_drd[b] = data_rdata_o;
      cyc();
      mem_data_ok_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    inst_req_i = 1'b1; data_rreq_i = 1'b1; data_wreq_i = 1'b1;
    mem_addr_ok_i = 1'b1; mem_data_ok_i = 1'b1;
    cyc(); cyc(); #1;
    checks++;
    if ({inst_grant_o, data_rgrant_o, data_wgrant_o} !== 3'b000)
      $display("FAIL reset_grants: got %b expected 000", {inst_grant_o, data_rgrant_o, data_wgrant_o});
    if ({inst_grant_o, data_rgrant_o, data_wgrant_o} !== 3'b000) errors++;
    checks++;
    if ({mem_req_o, mem_wr_o, mem_len_o, mem_wstrb_o} !== 10'd0 || mem_addr_o !== 32'd0 || mem_wdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem: req=%b wr=%b addr=%h len=%0d expected all 0", mem_req_o, mem_wr_o, mem_addr_o, mem_len_o);
    end
    checks++;
    if ({inst_rvalid_o, inst_rlast_o, data_rvalid_o, data_rlast_o, data_wdone_o} !== 5'd0 ||
        inst_rdata_o !== 32'd0 || data_rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_resp: got %b expected 00000", {inst_rvalid_o, inst_rlast_o, data_rvalid_o, data_rlast_o, data_wdone_o});
    end
    cyc();
    reset_i = 1'b0;
    inst_req_i = 1'b0; data_rreq_i = 1'b0; data_wreq_i = 1'b0;
    mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b0;
    m_starve = 0;
    #1;
    checks++;
    if ({inst_grant_o, data_rgrant_o, data_wgrant_o, mem_req_o} !== 4'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 0000", {inst_grant_o, data_rgrant_o, data_wgrant_o, mem_req_o});
    end
    cyc();
  endtask

  task automatic test_inst_refill();
    int who, wt;
    inst_addr_i = 32'h1FC0_0000; inst_uncached_i = 1'b0; inst_req_i = 1'b1;
    wait_grant(who, wt, 4);
    checks++;
    if (who != 1 || wt != 0) begin errors++; $display("FAIL refill_grant: got who=%0d wait=%0d expected who=1 wait=0", who, wt); end
    model_grant(1, 1'b1);
    for (int b = 0; b < 16; b++) beat_dat[b] = 32'hA0 + 32'(b);
    serve(1, 1'b1, $urandom_range(0, 2), LW, 1'b0);
    checks++;
    if (o_addr !== 32'h1FC0_0000 || o_len !== 4'd7 || o_wr !== 1'b0) begin
      errors++; $display("FAIL refill_addr: addr=%h len=%0d wr=%b expected 1fc00000/7/0", o_addr, o_len, o_wr);
    end
    checks++;
    if (!o_stable || !o_fell || o_gap != 0) begin
      errors++; $display("FAIL refill_phase: stable=%b fell=%b gap=%0d expected 1/1/0", o_stable, o_fell, o_gap);
    end
    for (int b = 0; b < LW; b++) begin
      checks++;
      if (o_iv[b] !== 1'b1 || o_dv[b] !== 1'b0 || o_il[b] !== (b == LW - 1) || o_ird[b] !== 32'hA0 + 32'(b)) begin
        errors++;
        $display("FAIL refill_beat%0d: valid=%b last=%b data=%h expected 1/%0d/%h", b, o_iv[b], o_il[b], o_ird[b], b == LW - 1, 32'hA0 + b);
      end
    end
  endtask

  task automatic test_simultaneous();
    int who, wt, w, el;
    logic [31:0] ea;
    inst_addr_i = $urandom & 32'hFFFF_FFE0; inst_uncached_i = 1'b0; inst_req_i = 1'b1;
    data_raddr_i = $urandom; data_uncached_i = 1'b0; data_rreq_i = 1'b1;
    data_waddr_i = $urandom; data_wdata_i = $urandom; data_wstrb_i = 4'($urandom); data_wreq_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      w = pick(data_wreq_i, data_rreq_i, inst_req_i);
      ea = (w == 1) ? inst_addr_i : (w == 2) ? data_raddr_i : data_waddr_i;
      el = exp_len(w, (w == 1) ? inst_uncached_i : data_uncached_i);
      wait_grant(who, wt, 3);
      checks++;
      if (who != w || wt != 0) begin errors++; $display("FAIL simul_grant%0d: got %0d wait=%0d expected %0d wait=0", t, who, wt, w); end
      model_grant(w, inst_req_i);
      for (int b = 0; b < 16; b++) beat_dat[b] = $urandom;
      checks++;
      if (w == 4) begin
        serve(w, 1'b1, $urandom_range(0, 2), 1, 1'b0);
        if (o_wr !== 1'b1 || o_len !== 4'd0 || o_addr !== ea || o_strb !== data_wstrb_i || o_wdata !== data_wdata_i || o_wd[0] !== 1'b1) begin
          errors++;
          $display("FAIL simul_write: wr=%b len=%0d addr=%h strb=%h wdata=%h done=%b expected 1/0/%h/%h/%h/1",
                   o_wr, o_len, o_addr, o_strb, o_wdata, o_wd[0], ea, data_wstrb_i, data_wdata_i);
        end
      end else begin
        serve(w, 1'b1, $urandom_range(0, 2), el + 1, 1'b0);
        if (o_wr !== 1'b0 || o_len !== 4'(el) || o_addr !== ea ||
            ((w == 1) ? o_iv[el] : o_dv[el]) !== 1'b1 || ((w == 1) ? o_il[el] : o_dl[el]) !== 1'b1) begin
          errors++;
          $display("FAIL simul_read%0d: wr=%b len=%0d addr=%h expected 0/%0d/%h", w, o_wr, o_len, o_addr, el, ea);
        end
      end
    end
  endtask

  task automatic test_starvation();
    int who, wt, w, n_wr_before;
    n_wr_before = -1;
    inst_addr_i = $urandom & 32'hFFFF_FFE0; inst_uncached_i = 1'b1; inst_req_i = 1'b1;
    data_waddr_i = $urandom; data_wdata_i = $urandom; data_wstrb_i = 4'hF; data_wreq_i = 1'b1;
    for (int t = 0; t < 7; t++) begin
      w = pick(data_wreq_i, data_rreq_i, inst_req_i);
      wait_grant(who, wt, 3);
      checks++;
      if (who != w) begin errors++; $display("FAIL starve_grant%0d: got %0d expected %0d", t, who, w); end
      if (who == 1 && n_wr_before < 0) n_wr_before = t;
      model_grant(w, inst_req_i);
      serve(w, w == 1, 0, 1, 1'b0);
    end
    data_wreq_i = 1'b0;
    checks++;
    if (n_wr_before != SL) begin errors++; $display("FAIL starve_count: inst granted after %0d writes expected %0d", n_wr_before, SL); end
  endtask

  task automatic test_addr_delay();
    int who, wt;
    logic [31:0] ea;
    ea = $urandom; data_raddr_i = ea; data_uncached_i = 1'b0; data_rreq_i = 1'b1;
    wait_grant(who, wt, 3);
    checks++;
    if (who != 2) begin errors++; $display("FAIL delay_grant: got %0d expected 2", who); end
    model_grant(2, inst_req_i);
    for (int b = 0; b < 16; b++) beat_dat[b] = $urandom;
    serve(2, 1'b1, 5, LW, 1'b1);
    checks++;
    if (!o_stable || o_addr !== ea || o_len !== 4'(LW - 1) || !o_fell) begin
      errors++; $display("FAIL delay_stable: stable=%b addr=%h len=%0d fell=%b expected 1/%h/%0d/1", o_stable, o_addr, o_len, o_fell, ea, LW - 1);
    end
    checks++;
    if (o_dv[LW-1] !== 1'b1 || o_dl[LW-1] !== 1'b1 || o_drd[LW-1] !== beat_dat[LW-1]) begin
      errors++; $display("FAIL delay_last: valid=%b last=%b data=%h expected 1/1/%h", o_dv[LW-1], o_dl[LW-1], o_drd[LW-1], beat_dat[LW-1]);
    end
  endtask

  task automatic test_uncached();
    int who, wt;
    data_raddr_i = 32'h1FAF_0000; data_uncached_i = 1'b1; data_rreq_i = 1'b1;
    wait_grant(who, wt, 3);
    checks++;
    if (who != 2) begin errors++; $display("FAIL unc_grant: got %0d expected 2", who); end
    model_grant(2, inst_req_i);
    beat_dat[0] = $urandom;
    serve(2, 1'b1, $urandom_range(0, 3), 1, 1'b0);
    checks++;
    if (o_len !== 4'd0 || o_addr !== 32'h1FAF_0000 || o_dv[0] !== 1'b1 || o_dl[0] !== 1'b1 || o_drd[0] !== beat_dat[0]) begin
      errors++; $display("FAIL unc_beat: len=%0d addr=%h valid=%b last=%b expected 0/1faf0000/1/1", o_len, o_addr, o_dv[0], o_dl[0]);
    end
    for (int k = 0; k < 3; k++) begin
      mem_data_ok_i = 1'b1; mem_rdata_i = $urandom;
      #1;
      checks++;
      if ({inst_rvalid_o, data_rvalid_o, data_wdone_o, mem_req_o} !== 4'd0) begin
        errors++; $display("FAIL spurious_ok%0d: got %b expected 0000", k, {inst_rvalid_o, data_rvalid_o, data_wdone_o, mem_req_o});
      end
      cyc();
    end
    mem_data_ok_i = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int who, wt;
    logic [31:0] ea;
    inst_addr_i = $urandom & 32'hFFFF_FFE0; inst_uncached_i = 1'b0; inst_req_i = 1'b1;
    wait_grant(who, wt, 3);
    model_grant(1, 1'b1);
    cyc();
    inst_req_i = 1'b0; mem_addr_ok_i = 1'b1;
    cyc();
    mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b1;
    repeat (3) begin mem_rdata_i = $urandom; cyc(); end
    #1;
    checks++;
    if (inst_rvalid_o !== 1'b1) begin errors++; $display("FAIL midburst_active: valid=%b expected 1", inst_rvalid_o); end
    reset_i = 1'b1;
    #1;
    checks++;
    if ({inst_rvalid_o, inst_rlast_o, mem_req_o, mem_wr_o, mem_len_o} !== 8'd0 || mem_addr_o !== 32'd0 || inst_rdata_o !== 32'd0) begin
      errors++; $display("FAIL midburst_reset: valid=%b req=%b addr=%h len=%0d expected all 0", inst_rvalid_o, mem_req_o, mem_addr_o, mem_len_o);
    end
    cyc();
    reset_i = 1'b0; mem_data_ok_i = 1'b0; m_starve = 0;
    ea = $urandom & 32'hFFFF_FFE0; inst_addr_i = ea; inst_req_i = 1'b1;
    wait_grant(who, wt, 3);
    checks++;
    if (who != 1 || wt != 0) begin errors++; $display("FAIL after_reset_grant: got %0d wait=%0d expected 1 wait=0", who, wt); end
    model_grant(1, 1'b1);
    for (int b = 0; b < 16; b++) beat_dat[b] = $urandom;
    serve(1, 1'b1, 1, LW, 1'b0);
    checks++;
    if (o_addr !== ea || o_len !== 4'(LW - 1) || o_iv[LW-1] !== 1'b1 || o_il[LW-1] !== 1'b1 || o_ird[0] !== beat_dat[0]) begin
      errors++; $display("FAIL after_reset_txn: addr=%h len=%0d expected %h/%0d", o_addr, o_len, ea, LW - 1);
    end
  endtask

  task automatic test_random();
    int who, wt, w, el;
    logic [31:0] ea, ed;
    logic [3:0] es;
    bit iv, dv, wd, last;
    for (int t = 0; t < 40; t++) begin
      if (!inst_req_i && $urandom_range(0, 1) == 1) begin
        inst_req_i = 1'b1; inst_addr_i = $urandom & 32'hFFFF_FFE0; inst_uncached_i = 1'($urandom_range(0, 1));
      end
      if (!data_rreq_i && $urandom_range(0, 1) == 1) begin
        data_rreq_i = 1'b1; data_raddr_i = $urandom; data_uncached_i = 1'($urandom_range(0, 1));
      end
      if (!data_wreq_i && $urandom_range(0, 2) == 0) begin
        data_wreq_i = 1'b1; data_waddr_i = $urandom; data_wdata_i = $urandom; data_wstrb_i = 4'($urandom);
      end
      if (!inst_req_i && !data_rreq_i && !data_wreq_i) begin
        inst_req_i = 1'b1; inst_addr_i = $urandom & 32'hFFFF_FFE0; inst_uncached_i = 1'b0;
      end
      w = pick(data_wreq_i, data_rreq_i, inst_req_i);
      ea = (w == 1) ? inst_addr_i : (w == 2) ? data_raddr_i : data_waddr_i;
      el = exp_len(w, (w == 1) ? inst_uncached_i : data_uncached_i);
      ed = data_wdata_i; es = data_wstrb_i;
      wait_grant(who, wt, 3);
      checks++;
      if (who != w || wt != 0) begin errors++; $display("FAIL rand%0d_grant: got %0d wait=%0d expected %0d wait=0", t, who, wt, w); end
      model_grant(w, inst_req_i);
      for (int b = 0; b < 16; b++) beat_dat[b] = $urandom;
      serve(w, 1'b1, $urandom_range(0, 3), el + 1, 1'b0);
      checks++;
      if (o_addr !== ea || o_len !== 4'(el) || o_wr !== (w == 4) || !o_stable || !o_fell || o_gap != 0 ||
          (w == 4 && (o_strb !== es || o_wdata !== ed))) begin
        errors++;
        $display("FAIL rand%0d_addr: addr=%h len=%0d wr=%b stable=%b expected %h/%0d/%0d/1", t, o_addr, o_len, o_wr, o_stable, ea, el, w == 4);
      end
      iv = (w == 1); dv = (w == 2); wd = (w == 4);
      for (int b = 0; b <= el; b++) begin
        last = (b == el);
        checks++;
        if (o_iv[b] !== iv || o_dv[b] !== dv || o_wd[b] !== wd || o_il[b] !== (iv && last) || o_dl[b] !== (dv && last) ||
            (iv && o_ird[b] !== beat_dat[b]) || (dv && o_drd[b] !== beat_dat[b])) begin
          errors++;
          $display("FAIL rand%0d_beat%0d: iv=%b dv=%b wd=%b il=%b dl=%b expected %b/%b/%b/%b/%b", t, b,
                   o_iv[b], o_dv[b], o_wd[b], o_il[b], o_dl[b], iv, dv, wd, iv && last, dv && last);
        end
      end
    end
    inst_req_i = 1'b0; data_rreq_i = 1'b0; data_wreq_i = 1'b0;
  endtask

  initial begin
    reset_i = 1'b1;
    inst_req_i = 1'b0; inst_addr_i = '0; inst_uncached_i = 1'b0;
    data_rreq_i = 1'b0; data_raddr_i = '0; data_uncached_i = 1'b0;
    data_wreq_i = 1'b0; data_waddr_i = '0; data_wstrb_i = '0; data_wdata_i = '0;
    mem_addr_ok_i = 1'b0; mem_data_ok_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_inst_refill();
    test_simultaneous();
    test_starvation();
    test_addr_delay();
    test_uncached();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
